// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM states, error codes,
// common command bytes and the PS/2 odd-parity helper.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_NACK   = 2'd1,
        ERR_REQ_TO = 2'd2,
        ERR_PKT_TO = 2'd3
    } err_t;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
    localparam logic [7:0] PS2_RSP_RESEND  = 8'hFE;

    // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake of the PS/2 host transmitter.
// master: the client issuing bytes; slave: the transmitter itself.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, tx_done, tx_error, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, tx_done, tx_error, err_code
    );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// ps2_line_sync: two-flop synchroniser for one PS/2 pad plus a falling-edge
// strobe. Flops reset to 1 because an idle PS/2 line floats high.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic fall
);
    logic sync_p0, sync_p1, prev_p2;

    // Metastability chain followed by a history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
        end else begin
            sync_p0 <= pad;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign fall  = prev_p2 & ~sync_p1;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the clock, issues request-to-send, shifts D0..D7 + odd parity on
// device falling edges, releases for the stop bit and checks the device ACK.
// Optional build macro PS2_TX_RETRY_EN: the first failure of a transfer
// silently restarts from INHIBIT with the latched byte; only a second failure
// is reported.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int REQ_TIMEOUT    = 1_500_000,
    parameter int PKT_TIMEOUT    = 200_000
) (
    input  logic           clk,
    input  logic           rst,
    ps2_host_tx_if.slave   bus,
    input  logic           ps2_clk_in,
    input  logic           ps2_data_in,
    output logic           ps2_clk_oe,
    output logic           ps2_data_oe
);
    // One counter serves inhibit timing, request timeout and packet timeout.
    localparam int LIM_A   = (INHIBIT_CYCLES > REQ_TIMEOUT + 1) ? INHIBIT_CYCLES : REQ_TIMEOUT + 1;
    localparam int CNT_LIM = (LIM_A > PKT_TIMEOUT + 1) ? LIM_A : PKT_TIMEOUT + 1;
    localparam int CNT_W   = $clog2(CNT_LIM + 1);

    state_t           state, next_state;
    err_t             err_q, err_kind;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic [3:0]       edge_n;
    logic [7:0]       byte_q;
    logic [8:0]       sh;
    logic             drv;
    logic             accept, err_now, retry_now;
    logic             clk_lvl, clk_fall, data_lvl, data_fall;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_clk_in),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk   (clk),
        .rst   (rst),
        .pad   (ps2_data_in),
        .level (data_lvl),
        .fall  (data_fall)
    );

    assign accept = (state == ST_IDLE) && bus.tx_valid;

`ifdef PS2_TX_RETRY_EN
    logic retried;

    // Remember whether this transfer has already used its one silent retry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retried <= 1'b0;
        else if (accept)
            retried <= 1'b0;
        else if (err_now)
            retried <= 1'b1;
    end

    assign retry_now = ~retried;
`else
    assign retry_now = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state and failure detection; a falling edge wins over a same-cycle timeout.
    always_comb begin
        next_state = state;
        err_now    = 1'b0;
        err_kind   = ERR_NONE;
        case (state)
            ST_IDLE:      if (bus.tx_valid) next_state = ST_INHIBIT;
            ST_INHIBIT:   if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) next_state = ST_RTS;
            ST_RTS: begin
                if (clk_fall) next_state = ST_SHIFT;
                else if (cnt > CNT_W'(REQ_TIMEOUT)) begin
                    err_now  = 1'b1;
                    err_kind = ERR_REQ_TO;
                end
            end
            ST_SHIFT: begin
                if (clk_fall && edge_n == 4'd9) next_state = ST_ACK;
                else if (!clk_fall && cnt > CNT_W'(PKT_TIMEOUT)) begin
                    err_now  = 1'b1;
                    err_kind = ERR_PKT_TO;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!data_lvl) next_state = ST_WAIT_IDLE;
                    else begin
                        err_now  = 1'b1;
                        err_kind = ERR_NACK;
                    end
                end else if (cnt > CNT_W'(PKT_TIMEOUT)) begin
                    err_now  = 1'b1;
                    err_kind = ERR_PKT_TO;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_lvl && data_lvl) next_state = ST_IDLE;
                else if (cnt > CNT_W'(PKT_TIMEOUT)) begin
                    err_now  = 1'b1;
                    err_kind = ERR_PKT_TO;
                end
            end
            default:      next_state = ST_IDLE;
        endcase
        if (err_now)
            next_state = retry_now ? ST_INHIBIT : ST_IDLE;
    end

    // The counter restarts on entry to INHIBIT, RTS and SHIFT; it keeps running
    // through ACK and WAIT_IDLE so the packet timeout spans edge 1 to bus idle.
    always_comb begin
        cnt_clr = (state == ST_IDLE) ||
                  ((next_state != state) &&
                   (next_state == ST_INHIBIT || next_state == ST_RTS || next_state == ST_SHIFT));
    end

    // Timing counter and device-edge counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            edge_n <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (state == ST_RTS && clk_fall)
                edge_n <= 4'd1;
            else if (state == ST_SHIFT && clk_fall)
                edge_n <= edge_n + 4'd1;
        end
    end

    // Byte latch and frame shifter; the shifter reloads during every INHIBIT so
    // a retry resends the original byte. Ones shift in, so edge 10 releases DATA.
    always_ff @(posedge clk) begin
        if (accept)
            byte_q <= bus.tx_data;
        if (state == ST_INHIBIT)
            sh <= {odd_parity(byte_q), byte_q};
        else if ((state == ST_RTS || state == ST_SHIFT) && clk_fall) begin
            drv <= ~sh[0];
            sh  <= {1'b1, sh[8:1]};
        end
    end

    // Error code: cleared on accept, set only by a reported failure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= ERR_NONE;
        else if (accept)
            err_q <= ERR_NONE;
        else if (err_now && !retry_now)
            err_q <= err_kind;
    end

    // Outputs decoded from state; the lines are released whenever IDLE.
    always_comb begin
        bus.tx_ready = (state == ST_IDLE);
        bus.busy     = (state != ST_IDLE);
        bus.tx_done  = (state == ST_WAIT_IDLE) && clk_lvl && data_lvl;
        bus.tx_error = err_now && !retry_now;
        bus.err_code = err_q;
        ps2_clk_oe   = (state == ST_INHIBIT);
        case (state)
            ST_INHIBIT: ps2_data_oe = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
            ST_RTS:     ps2_data_oe = 1'b1;
            ST_SHIFT:   ps2_data_oe = drv;
            default:    ps2_data_oe = 1'b0;
        endcase
    end

    // Receive-side edges on DATA are of no interest to the transmitter.
    logic unused_ok;
    assign unused_ok = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a behavioural PS/2 keyboard model.
// Expected frames and outcomes are queued when a byte is issued and popped
// when the transmitter reports done/error.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int REQ = 300;
    localparam int PKT = 600;
    localparam int H   = 10;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();
    logic ps2_clk_oe, ps2_data_oe;
    logic ps2_clk_in, ps2_data_in;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_TIMEOUT    (REQ),
        .PKT_TIMEOUT    (PKT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    int checks = 0;
    int passed = 0;
    logic [9:0] exp_frame_q[$];
    logic [1:0] exp_code_q[$];
    logic [9:0] rx_frame;

    // {stop, parity, D7..D0} as the device should observe it.
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        logic p;
        p = 1'b1;
        for (int i = 0; i < 8; i++) p = p ^ b[i];
        return {1'b1, p, b};
    endfunction

    task automatic send(input logic [7:0] b, input logic [1:0] code);
        @(negedge clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        exp_frame_q.push_back(frame_of(b));
        exp_code_q.push_back(code);
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic wait_rts();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            $display("FAIL rts_wait: no request-to-send within 3000 cycles");
        end
    endtask

    // Keyboard model: n_edges clock pulses; samples DATA on each rising edge,
    // pulls DATA low after rise 10 when ack is set.
    task automatic dev_clock(input int n_edges, input bit ack);
        rx_frame = '1;
        repeat (5) @(posedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(posedge clk);
            dev_clk_low = 1'b0;
            if (e <= 10) rx_frame[e-1] = ps2_data_in;
            if (e == 10 && ack) dev_data_low = 1'b1;
            repeat (H) @(posedge clk);
        end
        dev_clk_low = 1'b0;
        repeat (H) @(posedge clk);
        dev_data_low = 1'b0;
    endtask

    task automatic check_outcome(input bit cmp_frame, input string name);
        bit seen_done, seen_err;
        logic [1:0] exp_code;
        logic [9:0] exp_frame;
        seen_done = 1'b0;
        seen_err  = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (bus.tx_done) begin seen_done = 1'b1; break; end
            if (bus.tx_error) begin seen_err = 1'b1; break; end
        end
        exp_code  = exp_code_q.pop_front();
        exp_frame = exp_frame_q.pop_front();
        checks++;
        if (!seen_done && !seen_err) begin
            $display("FAIL %s: no done/error within 6000 cycles, expected code %0d", name, exp_code);
            return;
        end
        @(posedge clk); #1;
        if (seen_done != (exp_code == 2'd0) || bus.err_code !== exp_code)
            $display("FAIL %s outcome: done=%0b err_code=%0d, expected code %0d", name, seen_done, bus.err_code, exp_code);
        else passed++;
        checks++;
        if (bus.tx_ready !== 1'b1)
            $display("FAIL %s tx_ready: got %0b expected 1", name, bus.tx_ready);
        else passed++;
        if (seen_err) begin
            checks++;
            if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
                $display("FAIL %s release: clk_oe=%0b data_oe=%0b expected 0 0", name, ps2_clk_oe, ps2_data_oe);
            else passed++;
        end
        if (cmp_frame) begin
            checks++;
            if (rx_frame !== exp_frame)
                $display("FAIL %s frame: got %03h expected %03h", name, rx_frame, exp_frame);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++; if (bus.tx_ready !== 1'b1) $display("FAIL rst tx_ready: got %0b expected 1", bus.tx_ready); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst busy: got %0b expected 0", bus.busy); else passed++;
        checks++; if (ps2_clk_oe !== 1'b0) $display("FAIL rst clk_oe: got %0b expected 0", ps2_clk_oe); else passed++;
        checks++; if (ps2_data_oe !== 1'b0) $display("FAIL rst data_oe: got %0b expected 0", ps2_data_oe); else passed++;
        checks++; if (bus.err_code !== 2'd0) $display("FAIL rst err_code: got %0d expected 0", bus.err_code); else passed++;
        checks++; if (bus.tx_done !== 1'b0 || bus.tx_error !== 1'b0)
            $display("FAIL rst pulses: done=%0b error=%0b expected 0 0", bus.tx_done, bus.tx_error); else passed++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL post_rst idle: ready=%0b busy=%0b expected 1 0", bus.tx_ready, bus.busy); else passed++;
    endtask

    task automatic test_set_led();
        send(8'hED, 2'd0);
        checks++; if (bus.busy !== 1'b1 || ps2_clk_oe !== 1'b1)
            $display("FAIL set_led inhibit: busy=%0b clk_oe=%0b expected 1 1", bus.busy, ps2_clk_oe); else passed++;
        wait_rts();
        fork
            dev_clock(11, 1'b1);
            check_outcome(1'b1, "set_led");
        join
    endtask

    task automatic test_parity_inhibit();
        int n;
        send(8'h01, 2'd0);
        n = 0;
        while (ps2_clk_oe && n < 1000) begin
            n++;
            bus.tx_valid = (n == 1);
            bus.tx_data  = 8'h55;
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        checks++; if (n != INH) $display("FAIL inhibit_len: got %0d cycles expected %0d", n, INH); else passed++;
        wait_rts();
        fork
            dev_clock(11, 1'b1);
            check_outcome(1'b1, "byte_01");
        join
        checks++; if (rx_frame[8] !== 1'b0) $display("FAIL parity_01: got %0b expected 0", rx_frame[8]); else passed++;
    endtask

    task automatic test_nack();
        send(8'h3C, 2'd1);
        fork
            for (int a = 0; a < ATTEMPTS; a++) begin
                wait_rts();
                dev_clock(11, 1'b0);
            end
            check_outcome(1'b1, "nack");
        join
    endtask

    task automatic test_req_timeout();
        int k;
        bit seen;
        logic [1:0] exp_code;
        logic [9:0] exp_frame;
        send(8'h33, 2'd2);
        seen = 1'b0;
        k = 0;
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_rts();
            for (k = 0; k < 2000; k++) begin
                if (bus.tx_error) begin seen = 1'b1; break; end
                if (ps2_clk_oe) break;
                @(negedge clk);
            end
        end
        exp_code  = exp_code_q.pop_front();
        exp_frame = exp_frame_q.pop_front();
        checks++;
        if (!seen || k != REQ + 1)
            $display("FAIL req_timeout timing: error=%0b at %0d cycles expected 1 at %0d (frame %03h)", seen, k, REQ + 1, exp_frame);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if (bus.err_code !== exp_code) $display("FAIL req_timeout code: got %0d expected %0d", bus.err_code, exp_code);
        else passed++;
    endtask

    task automatic test_pkt_timeout();
        send(8'h5A, 2'd3);
        fork
            for (int a = 0; a < ATTEMPTS; a++) begin
                wait_rts();
                dev_clock(5, 1'b0);
            end
            check_outcome(1'b0, "pkt_timeout");
        join
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.tx_data  = 8'hA5;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        wait_rts();
        repeat (5) @(posedge clk);
        for (int e = 1; e <= 4; e++) begin
            dev_clk_low = 1'b1;
            if (e < 4) begin
                repeat (H) @(posedge clk);
                dev_clk_low = 1'b0;
                repeat (H) @(posedge clk);
            end
        end
        repeat (H / 2) @(posedge clk);
        @(negedge clk);
        checks++; if (ps2_data_oe !== 1'b1) $display("FAIL mid_d3: data_oe=%0b expected 1", ps2_data_oe); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0)
            $display("FAIL async_rst release: clk_oe=%0b data_oe=%0b expected 0 0", ps2_clk_oe, ps2_data_oe); else passed++;
        dev_clk_low = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.tx_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL after_rst idle: ready=%0b busy=%0b expected 1 0", bus.tx_ready, bus.busy); else passed++;
        repeat (20) @(negedge clk);
        send(8'hFF, 2'd0);
        wait_rts();
        fork
            dev_clock(11, 1'b1);
            check_outcome(1'b1, "resend_ff");
        join
    endtask

    initial begin
        test_reset();
        test_set_led();
        test_parity_inhibit();
        test_nack();
        test_req_timeout();
        test_pkt_timeout();
        test_reset_mid();
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
